// File: rtl/mux_out_qualifier.sv
// mux_out_qualifier
//   Registers the 4-state output of the 2:1 multiplexer primitive, debounces it
//   into a qualified level, flags runs of unknown samples and emits one-cycle
//   rise/fall events.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   UNK    | no level acquired yet; counting identical known samples
//   STABLE | out_q holds an accepted level
//   CAND   | a different known level is being counted toward acceptance
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mux_in     4-state multiplexer output
//   enable     sample/advance qualifier
//   clr_flags  synchronous clear of x_err / x_err_cnt
//   out_q      qualified level
//   out_valid  high once a first level has been acquired
//   rise_p     one-cycle pulse on an accepted 0->1 change
//   fall_p     one-cycle pulse on an accepted 1->0 change
//   x_err      sticky: an unknown run reached XTOL
//   x_err_cnt  number of unknown runs that reached XTOL (saturating)

module mux_out_qualifier #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 3,
    parameter int XTOL       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mux_in,
    input  logic       enable,
    input  logic       clr_flags,
    output logic       out_q,
    output logic       out_valid,
    output logic       rise_p,
    output logic       fall_p,
    output logic       x_err,
    output logic [7:0] x_err_cnt
);

    localparam int XW = (XTOL > 1) ? $clog2(XTOL + 1) : 1;
    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CNT);
    localparam logic [XW-1:0]    XTOL_TC   = XW'(XTOL);

    typedef enum logic [1:0] {
        UNK    = 2'd0,
        STABLE = 2'd1,
        CAND   = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic             s_val;
    logic             s_unk;
    logic             in_unk;
    logic             cand, cand_nx;
    logic [CNT_W-1:0] run_cnt, run_nx, run_inc;
    logic [XW-1:0]    x_run, xrun_nx;
    logic             out_nx, valid_nx, rise_nx, fall_nx, xerr_nx;
    logic [7:0]       xcnt_nx;

    // Anything other than a clean 0 or 1 (x or z) counts as unknown.
    assign in_unk = (mux_in !== 1'b0) && (mux_in !== 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_val     <= 1'b0;
            s_unk     <= 1'b1;      // no sample captured yet
            state     <= UNK;
            cand      <= 1'b0;
            run_cnt   <= '0;
            x_run     <= '0;
            out_q     <= 1'b0;
            out_valid <= 1'b0;
            rise_p    <= 1'b0;
            fall_p    <= 1'b0;
            x_err     <= 1'b0;
            x_err_cnt <= 8'd0;
        end else begin
            if (enable) begin
                s_val <= mux_in;
                s_unk <= in_unk;
            end
            state     <= state_nx;
            cand      <= cand_nx;
            run_cnt   <= run_nx;
            x_run     <= xrun_nx;
            out_q     <= out_nx;
            out_valid <= valid_nx;
            rise_p    <= rise_nx;
            fall_p    <= fall_nx;
            x_err     <= xerr_nx;
            x_err_cnt <= xcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        run_nx   = run_cnt;
        run_inc  = run_cnt + 1'b1;
        xrun_nx  = x_run;
        out_nx   = out_q;
        valid_nx = out_valid;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        xerr_nx  = x_err;
        xcnt_nx  = x_err_cnt;

        // Clear first so a coincident XTOL event below still sets the flags.
        if (clr_flags) begin
            xerr_nx = 1'b0;
            xcnt_nx = 8'd0;
        end

        if (enable) begin
            if (s_unk) begin
                run_nx = '0;
                if (state == CAND) begin
                    state_nx = STABLE;
                end
                // x_run saturates at XTOL so the error fires once per run.
                if (x_run != XTOL_TC) begin
                    xrun_nx = x_run + 1'b1;
                    if (xrun_nx == XTOL_TC) begin
                        xerr_nx = 1'b1;
                        if (xcnt_nx != 8'hFF) begin
                            xcnt_nx = xcnt_nx + 8'd1;
                        end
                    end
                end
            end else begin
                xrun_nx = '0;
                case (state)
                    UNK: begin
                        if (s_val != cand) begin
                            run_inc = CNT_W'(1);
                        end
                        cand_nx = s_val;
                        if (run_inc == STABLE_TC) begin
                            out_nx   = s_val;
                            valid_nx = 1'b1;
                            state_nx = STABLE;
                            run_nx   = '0;
                        end else begin
                            run_nx = run_inc;
                        end
                    end
                    STABLE: begin
                        if (s_val != out_q) begin
                            cand_nx = s_val;
                            if (STABLE_TC == CNT_W'(1)) begin
                                out_nx  = s_val;
                                rise_nx = s_val;
                                fall_nx = ~s_val;
                                run_nx  = '0;
                            end else begin
                                run_nx   = CNT_W'(1);
                                state_nx = CAND;
                            end
                        end
                    end
                    CAND: begin
                        if (s_val == out_q) begin
                            state_nx = STABLE;
                            run_nx   = '0;
                        end else if (run_inc == STABLE_TC) begin
                            out_nx   = s_val;
                            rise_nx  = s_val;
                            fall_nx  = ~s_val;
                            state_nx = STABLE;
                            run_nx   = '0;
                        end else begin
                            run_nx = run_inc;
                        end
                    end
                    default: begin
                        state_nx = UNK;
                        run_nx   = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_out_qualifier.sv
module tb_mux_out_qualifier;

    logic       clk;
    logic       rst_n;
    logic       mux_in;
    logic       enable;
    logic       clr_flags;
    logic       out_q;
    logic       out_valid;
    logic       rise_p;
    logic       fall_p;
    logic       x_err;
    logic [7:0] x_err_cnt;

    // Model of the upstream 2:1 multiplexer primitive.
    logic ctl, da, db;
    assign mux_in = ctl ? db : da;

    int errors = 0;
    int checks = 0;
    logic probe;
    logic four_state;
    logic [7:0] exp_cnt;
    logic       exp_err;

    mux_out_qualifier #(.STABLE_CNT(4), .CNT_W(3), .XTOL(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mux_in    (mux_in),
        .enable    (enable),
        .clr_flags (clr_flags),
        .out_q     (out_q),
        .out_valid (out_valid),
        .rise_p    (rise_p),
        .fall_p    (fall_p),
        .x_err     (x_err),
        .x_err_cnt (x_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input logic v);
        ctl = 1'b0;
        da  = v;
        db  = v;
    endtask

    task automatic setx();
        ctl = 1'bx;
        da  = 1'b0;
        db  = 1'b1;
    endtask

    initial begin
        probe = 1'bx;
        four_state = (probe !== 1'b0) && (probe !== 1'b1);
        exp_err = 1'b0;
        exp_cnt = 8'd0;

        rst_n = 1'b0; enable = 1'b0; clr_flags = 1'b0;
        setv(1'b0);
        step(); step();
        chk("rst_out_q", {7'd0, out_q}, 8'd0);
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_x_err", {7'd0, x_err}, 8'd0);
        chk("rst_x_cnt", x_err_cnt, 8'd0);
        rst_n = 1'b1;

        // First acquisition: capture edge + 4 evaluating edges.
        enable = 1'b1;
        setv(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("acq_valid_lo", {7'd0, out_valid}, 8'd0);
            chk("acq_rise_lo", {7'd0, rise_p}, 8'd0);
        end
        step();
        chk("acq_out_q", {7'd0, out_q}, 8'd1);
        chk("acq_valid", {7'd0, out_valid}, 8'd1);
        chk("acq_no_rise", {7'd0, rise_p}, 8'd0);

        // Two-sample glitch to 0 is rejected.
        setv(1'b0);
        step(); step();
        setv(1'b1);
        step(); step(); step();
        chk("glitch_out_q", {7'd0, out_q}, 8'd1);
        chk("glitch_no_fall", {7'd0, fall_p}, 8'd0);

        // Four samples of 0 are accepted with a single fall pulse.
        setv(1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fall_wait", {6'd0, fall_p, out_q}, 8'd1);
        end
        step();
        chk("fall_pulse", {6'd0, fall_p, out_q}, 8'd2);
        step();
        chk("fall_end", {6'd0, fall_p, out_q}, 8'd0);

        // Unknown run of 3 samples: control=x with differing data inputs.
        setx();
        step(); step(); step();
        if (four_state) begin exp_err = 1'b1; exp_cnt = 8'd1; end
        chk("xrun1_err", {7'd0, x_err}, {7'd0, exp_err});
        chk("xrun1_cnt", x_err_cnt, exp_cnt);
        setv(1'b0);
        step();
        chk("xrun1_once", x_err_cnt, exp_cnt);
        step();
        chk("xrun1_out_q", {7'd0, out_q}, 8'd0);

        // Second unknown run of 2 samples.
        setx();
        step(); step();
        setv(1'b0);
        step();
        if (four_state) exp_cnt = 8'd2;
        chk("xrun2_cnt", x_err_cnt, exp_cnt);
        step(); step();

        // clr_flags on the same edge the run reaches XTOL: set wins.
        setx();
        step(); step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        if (four_state) begin exp_err = 1'b1; exp_cnt = 8'd1; end
        else begin exp_err = 1'b0; exp_cnt = 8'd0; end
        chk("clr_coinc_err", {7'd0, x_err}, {7'd0, exp_err});
        chk("clr_coinc_cnt", x_err_cnt, exp_cnt);
        setv(1'b0);
        step(); step(); step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_err", {7'd0, x_err}, 8'd0);
        chk("clr_cnt", x_err_cnt, 8'd0);
        chk("clr_out_q", {7'd0, out_q}, 8'd0);

        // Freeze mid-CAND (run_cnt=2) with enable low.
        setv(1'b1);
        step(); step(); step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            setv(i[0]);
            step();
            chk("frz_out_q", {7'd0, out_q}, 8'd0);
            chk("frz_rise", {7'd0, rise_p}, 8'd0);
        end
        enable = 1'b1;
        setv(1'b1);
        step();
        chk("resume1", {6'd0, rise_p, out_q}, 8'd0);
        step();
        chk("resume2", {6'd0, rise_p, out_q}, 8'd3);
        step();
        chk("resume3", {6'd0, rise_p, out_q}, 8'd1);

        // Asynchronous reset between edges, mid-CAND.
        setv(1'b0);
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_q", {7'd0, out_q}, 8'd0);
        chk("arst_valid", {7'd0, out_valid}, 8'd0);
        chk("arst_pulses", {6'd0, rise_p, fall_p}, 8'd0);
        setv(1'b1);
        step(); step();
        chk("arst_hold", {6'd0, out_valid, out_q}, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reacq_wait", {7'd0, out_valid}, 8'd0);
        end
        step();
        chk("reacq_done", {6'd0, out_valid, out_q}, 8'd3);
        chk("reacq_no_rise", {7'd0, rise_p}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_out_qualifier.md
Name: mux_out_qualifier

Overview:
- Downstream stage of the combinational 2:1 multiplexer primitive; consumes its 4-state `mux` output.
- Registers that output and debounces it: a new level is accepted only after STABLE_CNT consecutive identical known samples.
- Flags runs of unknown (x/z) samples, such as those produced when `control` is x and the data inputs differ.
- Emits one-cycle rise/fall event pulses for downstream logic.

Parameters:
- STABLE_CNT, 4: consecutive identical known samples required to accept a level; legal range 1..2**CNT_W-1.
- CNT_W, 3: width of the run counter.
- XTOL, 2: consecutive unknown samples that raise an x error; legal range >=1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mux_in  input  1  4-state output of the multiplexer primitive.
- enable  input  1  sample/advance qualifier.
- clr_flags  input  1  synchronous clear of x_err and x_err_cnt.
- out_q  output  1  qualified level.
- out_valid  output  1  high once a first level has been acquired.
- rise_p  output  1  one-cycle pulse on an accepted 0->1 change.
- fall_p  output  1  one-cycle pulse on an accepted 1->0 change.
- x_err  output  1  sticky flag: an unknown run reached XTOL.
- x_err_cnt  output  8  count of unknown runs that reached XTOL; saturates at 255.

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronously):
  - out_q=0, out_valid=0, rise_p=0, fall_p=0, x_err=0, x_err_cnt=0.
  - State UNK; s_q=x-marked; cand=0; run_cnt=0; x_run=0.
  - Reset asserted mid-debounce discards the candidate; after release, acquisition restarts from UNK.
- Capture stage:
  - On each clk edge with enable=1, s_q<=mux_in.
  - s_q is classified as known (0/1) or unknown (x or z) using case equality.
  - The FSM evaluates s_q on the next enabled edge, so input-to-out_q latency is STABLE_CNT+0 edges after the first capturing edge. Example: STABLE_CNT=4, mux_in=1 captured at edge k, out_q=1 after edge k+4.
- enable=0: s_q, FSM, counters and outputs hold; rise_p and fall_p are forced 0.
- FSM, known sample s:
  - UNK:
    - s==cand: run_cnt++.
    - s!=cand: cand<=s, run_cnt<=1.
    - When the resulting run_cnt==STABLE_CNT: out_q<=s, out_valid<=1, go to STABLE, run_cnt<=0. No edge pulse on first acquisition.
  - STABLE:
    - s==out_q: stay.
    - s!=out_q: cand<=s, run_cnt<=1, go to CAND.
    - If STABLE_CNT==1, accept immediately instead (same rule as the CAND accept).
  - CAND:
    - s==out_q: glitch rejected; go to STABLE, run_cnt<=0, no pulse.
    - Otherwise run_cnt++. When it reaches STABLE_CNT: out_q<=s, pulse rise_p (s=1) or fall_p (s=0) for exactly one cycle, go to STABLE.
- FSM, unknown sample:
  - out_q holds. CAND aborts to STABLE; UNK stays in UNK; run_cnt<=0.
  - x_run increments, saturating at XTOL.
  - On the edge where x_run reaches XTOL: x_err<=1 and x_err_cnt++ (saturating). This happens once per run, not every cycle.
- A known sample clears x_run to 0.
- clr_flags=1 clears x_err and x_err_cnt on that edge.
  - If a new XTOL event coincides with clr_flags, the result is x_err=1, x_err_cnt=1 (set wins over clear).
- Pulses never overlap; rise_p and fall_p are never high together.
- out_q and out_valid are never x after reset.

Test Plan:
- Reset, then mux_in=1 held with enable=1 (STABLE_CNT=4) → out_q=1 and out_valid=1 after edge 4; rise_p stays 0.
- From STABLE out_q=1, apply mux_in=0 for 2 cycles then 1 → out_q stays 1, no fall_p; then 0 for 4 cycles → fall_p pulses exactly one cycle, out_q=0.
- Multiplexer driven with control=x, dataA=0, dataB=1 for 3 cycles (XTOL=2) → x_err=1, x_err_cnt=1, out_q unchanged; a second x run of 2 → x_err_cnt=2.
- clr_flags pulsed on the same edge x_run reaches XTOL → x_err=1, x_err_cnt=1.
- Toggle enable=0 for 5 cycles mid-CAND (run_cnt=2) while mux_in changes → state frozen; resume with 2 more matching samples → change accepted.
- Assert rst_n=0 mid-CAND, asynchronously between edges → all outputs 0 immediately; after release, reacquisition takes 4 samples.
